// File: rtl/alu_pkg.sv
// Shared ALU definitions: result flag bundle, adder defaults and the full-adder cell
// used by the pipelined adder slices.
package alu_pkg;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;

  localparam int ADDER_DEFAULT_STAGES = 4;

  // Returns {carry_out, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry slice built from full-adder cells; also exposes
// the carry into its MSB so the last pipeline stage can derive signed overflow.
module adder_slice
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  logic       carry;
  logic [1:0] fa;

  always_comb begin
    carry    = cin;
    c_msb_in = cin;
    fa       = '0;
    s        = '0;
    for (int i = 0; i < W; i++) begin
      c_msb_in = carry;
      fa       = full_add(a[i], b[i], carry);
      s[i]     = fa[0];
      carry    = fa[1];
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep add/subtract pipeline with a global-stall valid/ready handshake.
// Build option ADDER_PIPE_FLAGS_EN: when defined, out_ovf/out_zero/out_neg are live; otherwise tied to 0.
module pipelined_adder
  import alu_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = ADDER_DEFAULT_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_zero,
  output logic         out_neg
);

  localparam int W = (STAGES >= 1) ? N / STAGES : N;

  if (STAGES < 1) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be at least 1");
  end else if (N % STAGES != 0) begin : g_bad_split
    $error("pipelined_adder: N must be a multiple of STAGES");
  end

  // Handshake: a transfer happens on an edge where valid && ready. The whole pipe
  // advances together; it only holds when a result is waiting and not taken.
  logic advance;

  logic [N-1:0]      a_in  [STAGES];
  logic [N-1:0]      b_in  [STAGES];
  logic [N-1:0]      s_in  [STAGES];
  logic [N-1:0]      s_d   [STAGES];
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] c_in;

  logic [W-1:0]      slice_s [STAGES];
  logic [STAGES-1:0] slice_c;
  logic [STAGES-1:0] slice_m;

  logic [N-1:0]      a_q [STAGES];
  logic [N-1:0]      b_q [STAGES];
  logic [N-1:0]      s_q [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;

  alu_flags_t flags;

  assign out_valid = v_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [N-1:0] sum_next;

    if (k == 0) begin : g_head
      // Subtract enters as A + ~B + 1: invert B here and seed the carry with in_sub.
      assign a_in[0] = in_a;
      assign b_in[0] = in_b ^ {N{in_sub}};
      assign c_in[0] = in_sub;
      assign s_in[0] = '0;
      assign v_in[0] = in_valid;
    end else begin : g_link
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    adder_slice #(.W(W)) u_slice (
      .a        (a_in[k][k*W +: W]),
      .b        (b_in[k][k*W +: W]),
      .cin      (c_in[k]),
      .s        (slice_s[k]),
      .cout     (slice_c[k]),
      .c_msb_in (slice_m[k])
    );

    always_comb begin
      sum_next            = s_in[k];
      sum_next[k*W +: W]  = slice_s[k];
    end

    assign s_d[k] = sum_next;
  end

  // Data registers only load behind a valid token, so outputs stay put across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q <= v_in;
      for (int k = 0; k < STAGES; k++) begin
        if (v_in[k]) begin
          c_q[k] <= slice_c[k];
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_d[k];
        end
      end
    end
  end

`ifdef ADDER_PIPE_FLAGS_EN
  logic c_msb_q;
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_msb_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (advance && v_in[STAGES-1]) begin
      c_msb_q <= slice_m[STAGES-1];
      zero_q  <= (s_d[STAGES-1] == '0);
    end
  end

  assign flags = '{cout: c_q[STAGES-1],
                   ovf:  c_msb_q ^ c_q[STAGES-1],
                   zero: zero_q,
                   neg:  s_q[STAGES-1][N-1]};
`else
  assign flags = '{cout: c_q[STAGES-1], ovf: 1'b0, zero: 1'b0, neg: 1'b0};
`endif

  // Operands past the last slice and the inner MSB carries have no consumer.
  logic unused_tail;
  assign unused_tail = ^{slice_m, a_q[STAGES-1], b_q[STAGES-1]};

  assign out_sum  = s_q[STAGES-1];
  assign out_cout = flags.cout;
  assign out_ovf  = flags.ovf;
  assign out_zero = flags.zero;
  assign out_neg  = flags.neg;

endmodule
